mem_write_checker: RTL and testbench
====================================

# mem_write_checker

Synthesizable self-check block that watches the processor data-memory write port (MemWrite, DataAdr, WriteData) and compares observed stores against a programmed table of up to NUM_EXP expected (address, data) pairs. It sits beside `top` in system benches and FPGA bring-up builds. It generalises the single hard-coded "write 254 to address 128" success check to a parametrised, ordered sequence with a cycle timeout and captured failure information.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- NUM_EXP, 4, expected-table depth (≥1)
- CNT_W, 16, cycle-counter width
- TIMEOUT, 1000, RUN cycles before timeout fail (< 2^CNT_W)
- STRICT, 1, 1 = any non-matching write fails; 0 = non-matching writes are skipped

Ports:
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  asynchronous, active-high
- MemWrite  in  1  store strobe from core
- DataAdr  in  ADDR_W  store address
- WriteData  in  DATA_W  store data
- exp_we  in  1  table write strobe
- exp_idx  in  $clog2(NUM_EXP) (min 1)  table entry index
- exp_addr  in  ADDR_W  expected address
- exp_data  in  DATA_W  expected data
- n_exp  in  $clog2(NUM_EXP+1)  number of entries to check; sampled on start
- start  in  1  begin checking (pulse)
- busy  out  1  state == RUN
- done  out  1  state ∈ {PASS, FAIL}
- pass  out  1  state == PASS
- fail  out  1  state == FAIL
- timeout  out  1  fail cause was timeout
- match_cnt  out  $clog2(NUM_EXP+1)  entries matched so far
- cycle_cnt  out  CNT_W  RUN cycles elapsed
- fail_addr  out  ADDR_W  DataAdr of the offending write
- fail_data  out  DATA_W  WriteData of the offending write

## Operation
- States: IDLE, RUN, PASS, FAIL. Reset → IDLE. All outputs are 0 at reset; table contents are 0.
- Table load: exp_we writes entry exp_idx in IDLE, PASS, or FAIL. It is ignored in RUN. exp_idx ≥ NUM_EXP is ignored.
- IDLE/PASS/FAIL + start:
  - Latch n_exp. If n_exp is 0 or > NUM_EXP, clamp to NUM_EXP.
  - Clear match_cnt, cycle_cnt, timeout, fail_addr, fail_data.
  - Go to RUN.
- RUN, each cycle:
  - cycle_cnt increments.
  - If MemWrite=1 and (DataAdr, WriteData) equals entry[match_cnt] (exact compare, both fields), match_cnt increments. If the new match_cnt equals the latched n_exp, go to PASS.
  - If MemWrite=1 and there is a mismatch:
    - STRICT=1: capture fail_addr/fail_data and go to FAIL.
    - STRICT=0: no action.
  - If there is no PASS/FAIL transition and cycle_cnt+1 == TIMEOUT: set timeout=1 and go to FAIL. fail_addr/fail_data stay 0.
- Priority in the same cycle: final match (PASS) > mismatch fail > timeout.
- start in RUN is ignored.
- PASS/FAIL hold until reset or start.
- Comparisons use ===-free RTL equality. X on inputs is the bench's problem.

## Timing
- A write sampled at edge k updates match_cnt and state after edge k; the outputs are visible in cycle k+1.
- A write present in the same cycle start is sampled is not checked. Checking begins the cycle after start.
- PASS latency: one cycle after the final matching write.
- Timeout: with no matches, fail=1 exactly TIMEOUT cycles after the start edge.
- The cycle_cnt counter does not wrap: it freezes on leaving RUN.
- Asynchronous reset mid-RUN forces IDLE and clears all outputs immediately. The table is also cleared.

## Configuration
- MEM_WRITE_CHECKER_LOG_EN defined:
  - On entering PASS, simulation prints "Simulation succeeded".
  - On entering FAIL, it prints "Simulation failed" with fail_addr/fail_data, or "timeout" with cycle_cnt.
  - These are simulation-only $display statements.
- Undefined: no $display, fully synthesizable. Functional behaviour is identical either way.

## Structure
- Shared package `mem_write_checker_pkg`:
  - state encoding (IDLE=0, RUN=1, PASS=2, FAIL=3)
  - fail-cause constants (MISMATCH, TIMEOUT)
  - a clog2 helper
- Sub-module `exp_table`: NUM_EXP-entry register file with a synchronous write port and an asynchronous read port indexed by match_cnt. It takes async reset to zero.
- The FSM, counters, and capture registers live in mem_write_checker.

## Test plan
- Program entry0=(128,254), n_exp=1, start. Drive the write (128,254) in cycle 3 → pass=1 in cycle 4, match_cnt=1, cycle_cnt=3.
- Program (0,7),(4,9),(128,254), n_exp=3, STRICT=1. Drive writes (0,7),(4,9),(128,253) → fail=1, timeout=0, fail_addr=128, fail_data=253, match_cnt=2.
- Same table with STRICT=0. Drive (0,7),(8,1),(4,9),(128,254) → the (8,1) write is skipped and pass=1, match_cnt=3.
- TIMEOUT=20, n_exp=1, no writes → fail=1 and timeout=1 exactly 20 cycles after start; cycle_cnt=20.
- The final matching write lands on the same cycle the timeout would fire → pass=1, timeout=0. exp_we during RUN leaves the table unchanged.
- Assert reset mid-RUN with match_cnt=1 → busy=0 and all outputs 0 immediately. A new start without reloading the table fails on the first write (128,254), because the cleared entry0 is (0,0).

Source files
------------

// File: rtl/mem_write_checker_pkg.sv
// Shared types and helpers for the memory-write checker.
package mem_write_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_e;

  typedef enum logic {
    CAUSE_MISMATCH = 1'b0,
    CAUSE_TIMEOUT  = 1'b1
  } fail_cause_e;

  // Ceiling log2 that never returns less than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mem_write_checker_exp_table.sv
// Expected (address, data) table: synchronous write, async read by match index.
module exp_table
  import mem_write_checker_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_EXP = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   we_i,
  input  logic [clog2_min1(NUM_EXP)-1:0]         widx_i,
  input  logic [ADDR_W-1:0]                      waddr_i,
  input  logic [DATA_W-1:0]                      wdata_i,
  input  logic [clog2_min1(NUM_EXP+1)-1:0]       ridx_i,
  output logic [ADDR_W-1:0]                      raddr_o,
  output logic [DATA_W-1:0]                      rdata_o
);

  localparam int IDX_W = clog2_min1(NUM_EXP);
  localparam int RD_W  = clog2_min1(NUM_EXP + 1);

  logic [ADDR_W-1:0] addr_q [NUM_EXP];
  logic [DATA_W-1:0] data_q [NUM_EXP];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_EXP; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      // Out-of-range indices simply match no entry.
      for (int i = 0; i < NUM_EXP; i++) begin
        if (we_i && (widx_i == IDX_W'(i))) begin
          addr_q[i] <= waddr_i;
          data_q[i] <= wdata_i;
        end
      end
    end
  end

  always_comb begin
    raddr_o = '0;
    rdata_o = '0;
    for (int i = 0; i < NUM_EXP; i++) begin
      if (ridx_i == RD_W'(i)) begin
        raddr_o = addr_q[i];
        rdata_o = data_q[i];
      end
    end
  end

endmodule

// File: rtl/mem_write_checker.sv
// Ordered store checker with cycle timeout and failure capture.
// Define MEM_WRITE_CHECKER_LOG_EN for simulation-only pass/fail messages.
module mem_write_checker
  import mem_write_checker_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_EXP = 4,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000,
  parameter bit STRICT  = 1'b1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              MemWrite,
  input  logic [ADDR_W-1:0]                 DataAdr,
  input  logic [DATA_W-1:0]                 WriteData,
  input  logic                              exp_we,
  input  logic [clog2_min1(NUM_EXP)-1:0]    exp_idx,
  input  logic [ADDR_W-1:0]                 exp_addr,
  input  logic [DATA_W-1:0]                 exp_data,
  input  logic [clog2_min1(NUM_EXP+1)-1:0]  n_exp,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic                              pass,
  output logic                              fail,
  output logic                              timeout,
  output logic [clog2_min1(NUM_EXP+1)-1:0]  match_cnt,
  output logic [CNT_W-1:0]                  cycle_cnt,
  output logic [ADDR_W-1:0]                 fail_addr,
  output logic [DATA_W-1:0]                 fail_data
);

  localparam int MC_W = clog2_min1(NUM_EXP + 1);
  localparam logic [MC_W-1:0] NUM_MC = MC_W'(NUM_EXP);

  state_e            state_q;
  fail_cause_e       cause_q;
  logic [MC_W-1:0]   n_q, match_q, match_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic [ADDR_W-1:0] fail_addr_q, entry_addr;
  logic [DATA_W-1:0] fail_data_q, entry_data;
  logic              tbl_we, hit, go_pass, go_mismatch, go_timeout;

  assign tbl_we = exp_we && (state_q != ST_RUN);

  exp_table #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .NUM_EXP(NUM_EXP)
  ) u_table (
    .clk    (clk),
    .reset  (reset),
    .we_i   (tbl_we),
    .widx_i (exp_idx),
    .waddr_i(exp_addr),
    .wdata_i(exp_data),
    .ridx_i (match_q),
    .raddr_o(entry_addr),
    .rdata_o(entry_data)
  );

  // Final match beats a strict mismatch, which beats timeout.
  always_comb begin
    match_d     = match_q + 1'b1;
    cycle_d     = cycle_q + 1'b1;
    hit         = MemWrite && (DataAdr == entry_addr) && (WriteData == entry_data);
    go_pass     = (state_q == ST_RUN) && hit && (match_d == n_q);
    go_mismatch = (state_q == ST_RUN) && STRICT && MemWrite && !hit;
    go_timeout  = (state_q == ST_RUN) && !go_pass && !go_mismatch &&
                  (cycle_d == CNT_W'(TIMEOUT));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cause_q     <= CAUSE_MISMATCH;
      n_q         <= '0;
      match_q     <= '0;
      cycle_q     <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          cycle_q <= cycle_d;
          if (hit) match_q <= match_d;
          if (go_pass) begin
            state_q <= ST_PASS;
          end else if (go_mismatch) begin
            state_q     <= ST_FAIL;
            fail_addr_q <= DataAdr;
            fail_data_q <= WriteData;
          end else if (go_timeout) begin
            state_q <= ST_FAIL;
            cause_q <= CAUSE_TIMEOUT;
          end
        end
        default: begin
          if (start) begin
            n_q         <= ((n_exp == '0) || (n_exp > NUM_MC)) ? NUM_MC : n_exp;
            match_q     <= '0;
            cycle_q     <= '0;
            cause_q     <= CAUSE_MISMATCH;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            state_q     <= ST_RUN;
          end
        end
      endcase
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign pass      = (state_q == ST_PASS);
  assign fail      = (state_q == ST_FAIL);
  assign done      = pass || fail;
  assign timeout   = (cause_q == CAUSE_TIMEOUT);
  assign match_cnt = match_q;
  assign cycle_cnt = cycle_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;

`ifdef MEM_WRITE_CHECKER_LOG_EN
  always @(posedge clk) begin
    if (!reset) begin
      if (go_pass)
        $display("Simulation succeeded");
      else if (go_mismatch)
        $display("Simulation failed: addr=%0h data=%0h", DataAdr, WriteData);
      else if (go_timeout)
        $display("Simulation failed: timeout after %0d cycles", cycle_d);
    end
  end
`else
`endif

endmodule

// File: tb/tb_mem_write_checker.sv
// Scoreboard bench: strict and lenient checkers share stimulus, each has its own queue.
module tb_mem_write_checker;

  localparam int NUM = 5;
  localparam int TO  = 20;

  typedef struct {
    bit          pass;
    bit          tmo;
    int          mcnt;
    int          cyc;
    logic [31:0] fa;
    logic [31:0] fd;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_we = 1'b0;
  logic [31:0] adr = '0, wdat = '0;
  logic        exp_we = 1'b0;
  logic [2:0]  exp_idx = '0;
  logic [31:0] exp_addr = '0, exp_data = '0;
  logic [2:0]  n_exp = '0;
  logic        start = 1'b0;

  logic [1:0]  busy, done, pass, fail, tmo;
  logic [2:0]  mcnt [2];
  logic [15:0] ccnt [2];
  logic [31:0] fa [2];
  logic [31:0] fd [2];

  always #5 clk = ~clk;

  mem_write_checker #(.NUM_EXP(NUM), .TIMEOUT(TO), .STRICT(1'b1)) dut_s (
    .clk(clk), .reset(reset), .MemWrite(mem_we), .DataAdr(adr), .WriteData(wdat),
    .exp_we(exp_we), .exp_idx(exp_idx), .exp_addr(exp_addr), .exp_data(exp_data),
    .n_exp(n_exp), .start(start), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .fail(fail[0]), .timeout(tmo[0]), .match_cnt(mcnt[0]), .cycle_cnt(ccnt[0]),
    .fail_addr(fa[0]), .fail_data(fd[0]));

  mem_write_checker #(.NUM_EXP(NUM), .TIMEOUT(TO), .STRICT(1'b0)) dut_n (
    .clk(clk), .reset(reset), .MemWrite(mem_we), .DataAdr(adr), .WriteData(wdat),
    .exp_we(exp_we), .exp_idx(exp_idx), .exp_addr(exp_addr), .exp_data(exp_data),
    .n_exp(n_exp), .start(start), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .fail(fail[1]), .timeout(tmo[1]), .match_cnt(mcnt[1]), .cycle_cnt(ccnt[1]),
    .fail_addr(fa[1]), .fail_data(fd[1]));

  int n_cmp = 0, n_bad = 0;
  int edge_cnt = 0, start_edge = 0;
  exp_t q0[$], q1[$];

  // Reference model state: table contents, effective count, per-cycle writes.
  logic [31:0] m_a [NUM];
  logic [31:0] m_d [NUM];
  int          m_n;
  bit          wv[$];
  logic [31:0] wa[$], wd[$];
  logic [31:0] pool [4] = '{32'd0, 32'd4, 32'd8, 32'd128};

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string nm, input longint act, input longint expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic exp_t predict(input bit strict);
    exp_t e;
    int m;
    bit v;
    logic [31:0] a, d;
    e.pass = 0; e.tmo = 0; e.mcnt = 0; e.cyc = 0; e.fa = '0; e.fd = '0;
    m = 0;
    for (int c = 1; c <= TO; c++) begin
      v = 1'b0; a = '0; d = '0;
      if (c <= wv.size()) begin v = wv[c-1]; a = wa[c-1]; d = wd[c-1]; end
      if (v && a == m_a[m] && d == m_d[m]) begin
        m++;
        if (m == m_n) begin e.pass = 1; e.mcnt = m; e.cyc = c; return e; end
      end else if (v && strict) begin
        e.mcnt = m; e.cyc = c; e.fa = a; e.fd = d; return e;
      end
      if (c == TO) begin e.tmo = 1; e.mcnt = m; e.cyc = c; return e; end
    end
    return e;
  endfunction

  task automatic check_done(input int k, input exp_t e);
    string s;
    s = (k == 0) ? "strict" : "lenient";
    chk({s, ".pass"}, pass[k], e.pass);
    chk({s, ".fail"}, fail[k], !e.pass);
    chk({s, ".timeout"}, tmo[k], e.tmo);
    chk({s, ".match_cnt"}, mcnt[k], e.mcnt);
    chk({s, ".cycle_cnt"}, ccnt[k], e.cyc);
    chk({s, ".latency"}, edge_cnt - start_edge, e.cyc);
    chk({s, ".fail_addr"}, fa[k], e.fa);
    chk({s, ".fail_data"}, fd[k], e.fd);
  endtask

  bit prev0 = 0, prev1 = 0;
  always @(negedge clk) begin
    if (done[0] && !prev0) begin
      if (q0.size() == 0) chk("strict.unexpected_done", 1, 0);
      else check_done(0, q0.pop_front());
    end
    prev0 = done[0];
  end
  always @(negedge clk) begin
    if (done[1] && !prev1) begin
      if (q1.size() == 0) chk("lenient.unexpected_done", 1, 0);
      else check_done(1, q1.pop_front());
    end
    prev1 = done[1];
  end

  task automatic check_zero();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("zero.busy[%0d]", k), busy[k], 0);
      chk($sformatf("zero.done[%0d]", k), done[k], 0);
      chk($sformatf("zero.pass[%0d]", k), pass[k], 0);
      chk($sformatf("zero.fail[%0d]", k), fail[k], 0);
      chk($sformatf("zero.timeout[%0d]", k), tmo[k], 0);
      chk($sformatf("zero.match_cnt[%0d]", k), mcnt[k], 0);
      chk($sformatf("zero.cycle_cnt[%0d]", k), ccnt[k], 0);
      chk($sformatf("zero.fail_addr[%0d]", k), fa[k], 0);
      chk($sformatf("zero.fail_data[%0d]", k), fd[k], 0);
    end
  endtask

  task automatic tbl_write(input int idx, input logic [31:0] a, input logic [31:0] d);
    exp_we = 1'b1; exp_idx = 3'(idx); exp_addr = a; exp_data = d;
    @(posedge clk); #1;
    exp_we = 1'b0;
    if (idx < NUM) begin m_a[idx] = a; m_d[idx] = d; end
  endtask

  task automatic clr_writes();
    wv.delete(); wa.delete(); wd.delete();
  endtask

  task automatic wr(input bit v, input logic [31:0] a, input logic [31:0] d);
    wv.push_back(v); wa.push_back(a); wd.push_back(d);
  endtask

  // we_at / st_at: cycle at which a table write / extra start is issued mid-run (0 = never).
  task automatic run(input int n, input bit inj, input int we_at, input int st_at);
    m_n = (n == 0 || n > NUM) ? NUM : n;
    start = 1'b1; n_exp = 3'(n);
    if (inj) begin
      mem_we = 1'b1; adr = 32'hDEAD_0000 | 32'($urandom_range(0, 255)); wdat = $urandom;
    end
    @(posedge clk); #1;
    start_edge = edge_cnt;
    start = 1'b0; mem_we = 1'b0;
    chk("busy.strict", busy[0], 1);
    chk("busy.lenient", busy[1], 1);
    q0.push_back(predict(1'b1));
    q1.push_back(predict(1'b0));
    for (int c = 1; c <= wv.size(); c++) begin
      mem_we = wv[c-1]; adr = wa[c-1]; wdat = wd[c-1];
      start = (c == st_at);
      exp_we = (c == we_at);
      if (c == we_at) begin exp_idx = 3'd0; exp_addr = 32'd128; exp_data = 32'd0; end
      @(posedge clk); #1;
    end
    mem_we = 1'b0; exp_we = 1'b0; start = 1'b0;
    for (int i = 0; i < TO + 4 && done != 2'b11; i++) begin
      @(posedge clk); #1;
    end
    if (done != 2'b11) chk("run_completes", done, 3);
    @(posedge clk); #1;
  endtask

  initial begin
    int p, neff, n;
    for (int i = 0; i < NUM; i++) begin m_a[i] = '0; m_d[i] = '0; end

    #12;
    check_zero();
    @(posedge clk); #1;
    reset = 1'b0;

    // Single store (128,254) in cycle 3.
    tbl_write(0, 32'd128, 32'd254);
    clr_writes(); wr(0, 0, 0); wr(0, 0, 0); wr(1, 32'd128, 32'd254);
    run(1, 1'b0, 0, 0);

    // Three-entry sequence, wrong data on the last store.
    tbl_write(0, 32'd0, 32'd7); tbl_write(1, 32'd4, 32'd9); tbl_write(2, 32'd128, 32'd254);
    clr_writes(); wr(1, 0, 7); wr(1, 4, 9); wr(1, 128, 253);
    run(3, 1'b1, 0, 0);

    // Stray store between matches.
    clr_writes(); wr(1, 0, 7); wr(1, 8, 1); wr(1, 4, 9); wr(1, 128, 254);
    run(3, 1'b0, 0, 0);

    // No stores at all.
    clr_writes();
    run(1, 1'b0, 0, 0);

    // Final match on the timeout cycle, with a table write and start during RUN.
    tbl_write(0, 32'd128, 32'd254);
    clr_writes();
    for (int i = 0; i < TO - 1; i++) wr(0, 0, 0);
    wr(1, 32'd128, 32'd254);
    run(1, 1'b0, 5, 10);

    // Async reset mid-RUN after one match.
    tbl_write(0, 32'd128, 32'd254); tbl_write(1, 32'd4, 32'd9);
    n_exp = 3'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mem_we = 1'b1; adr = 32'd128; wdat = 32'd254;
    @(posedge clk); #1;
    mem_we = 1'b0;
    chk("pre_reset.match_cnt[0]", mcnt[0], 1);
    chk("pre_reset.match_cnt[1]", mcnt[1], 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_zero();
    for (int i = 0; i < NUM; i++) begin m_a[i] = '0; m_d[i] = '0; end
    @(posedge clk); #1;
    reset = 1'b0;
    clr_writes(); wr(1, 32'd128, 32'd254);
    run(1, 1'b0, 0, 0);

    // Randomised runs.
    repeat (30) begin
      repeat ($urandom_range(1, 6))
        tbl_write($urandom_range(0, 7), pool[$urandom_range(0, 3)], 32'($urandom_range(0, 3)));
      n = $urandom_range(0, 7);
      neff = (n == 0 || n > NUM) ? NUM : n;
      clr_writes();
      p = 0;
      for (int j = 0; j < $urandom_range(1, 14); j++) begin
        int r;
        r = $urandom_range(0, 9);
        if (r < 6 && p < neff) begin wr(1, m_a[p], m_d[p]); p++; end
        else if (r < 8) wr(1, pool[$urandom_range(0, 3)], 32'($urandom_range(0, 3)));
        else wr(0, 0, 0);
      end
      run(n, 1'($urandom_range(0, 1)), 0, 0);
    end

    chk("strict.queue_drained", q0.size(), 0);
    chk("lenient.queue_drained", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
